regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of each register.
REQ-002 SHALL have parameter NREGS, default 16, meaning register count; index NREGS-1 is the PC alias, not stored.
REQ-003 SHALL have parameter ABITS, default 4, meaning address width; NREGS <= 2**ABITS.
REQ-004 SHALL have port clk  input  1  meaning single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning reset; synchronous and active-low.
REQ-006 SHALL have port we3  input  1  meaning single write enable.
REQ-007 SHALL have port wa3  input  ABITS  meaning single write address (Rd).
REQ-008 SHALL have port wd3  input  WIDTH  meaning single write data.
REQ-009 SHALL have port lwe  input  1  meaning long-multiply write request (SMULL/UMULL).
REQ-010 SHALL have port lwa_lo  input  ABITS  meaning RdLo address.
REQ-011 SHALL have port lwa_hi  input  ABITS  meaning RdHi address.
REQ-012 SHALL have port lwd  input  2*WIDTH  meaning 64-bit product; low half to RdLo, high half to RdHi.
REQ-013 SHALL have ports ra1, ra2  input  ABITS  meaning read addresses.
REQ-014 SHALL have port r15  input  WIDTH  meaning PC+8 value returned for address NREGS-1.
REQ-015 SHALL have ports rd1, rd2  output  WIDTH  meaning combinational read data.
REQ-016 SHALL have port busy  output  1  meaning block cannot accept a write this cycle.

Function
REQ-017 SHALL implement FSM states CLEAR, IDLE, HI.
REQ-018 CLEAR: one register zeroed per cycle, index 0 upward, via counter; after index NREGS-2 written, next state IDLE; busy=1 throughout.
REQ-019 IDLE, lwe=1: lwd[WIDTH-1:0] written to lwa_lo this edge; lwd[2*WIDTH-1:WIDTH] and lwa_hi captured; next state HI.
REQ-020 HI: captured high word written to captured address this edge; next state IDLE; busy=1 in HI.
REQ-021 IDLE, we3=1 and lwe=0: wd3 written to wa3; stays IDLE.
REQ-022 IDLE, we3=1 and lwe=1 same cycle: lwe wins; we3 write dropped.
REQ-023 we3 and lwe while busy=1 SHALL be ignored, no state or register change; caller holds request until busy=0.
REQ-024 Any write addressed to NREGS-1 or above SHALL be discarded; FSM sequencing unaffected.
REQ-025 lwa_lo == lwa_hi: register ends holding high word (HI write occurs last).
REQ-026 rd1/rd2 SHALL return r15 when address == NREGS-1, else array content; reads valid in all states (zeros progressively in CLEAR).
REQ-027 Reads SHALL show written value from the cycle after the write edge; no same-cycle bypass.
REQ-028 busy SHALL be registered state decode only, no combinational path from we3/lwe.

Reset
REQ-029 reset=0 at a clk edge SHALL force state CLEAR, clear counter to 0, drop any pending HI write; busy=1 from next cycle.
REQ-030 Reset mid-HI or mid-CLEAR SHALL restart the clear from index 0; no partial high-word write occurs.
REQ-031 With reset held low, no register written; clear begins first edge with reset=1; IDLE reached NREGS-1 cycles later (15 at default).

Verification
REQ-032 Release reset, poll ra1=0..14 after busy falls -> all rd1=0; busy high exactly 15 cycles.
REQ-033 IDLE, we3=1, wa3=3, wd3=0xDEADBEEF; next cycle ra1=3 -> rd1=0xDEADBEEF; ra2=15, r15=0x108 -> rd2=0x108.
REQ-034 IDLE, lwe=1, lwa_lo=4, lwa_hi=5, lwd=0x11112222_33334444 -> r4=0x33334444 after edge 1, busy=1 one cycle, r5=0x11112222 after edge 2.
REQ-035 During HI, we3=1 wa3=6 wd3=7 -> r6 unchanged; same cycle both we3 (wa3=2) and lwe -> only long write executes.
REQ-036 lwe with lwa_lo=lwa_hi=8, lwd=0xAAAA0000_0000BBBB -> r8=0xAAAA0000; we3 to wa3=15 -> no register changes.
REQ-037 reset=0 asserted during HI -> high word never written, CLEAR restarts at 0, all registers read 0 after 15 cycles.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised register file with a self-clearing sequencer and a two-cycle long-multiply
// write path. The highest index is a PC alias returned from the r15 input and is never stored.
module regfile_param #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 16,
    parameter int unsigned ABITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we3,
    input  logic [ABITS-1:0]   wa3,
    input  logic [WIDTH-1:0]   wd3,
    input  logic               lwe,
    input  logic [ABITS-1:0]   lwa_lo,
    input  logic [ABITS-1:0]   lwa_hi,
    input  logic [2*WIDTH-1:0] lwd,
    input  logic [ABITS-1:0]   ra1,
    input  logic [ABITS-1:0]   ra2,
    input  logic [WIDTH-1:0]   r15,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2,
    output logic               busy
);

    localparam int unsigned    NStore  = NREGS - 1;
    localparam logic [ABITS-1:0] PcAddr  = ABITS'(NREGS - 1);
    localparam logic [ABITS-1:0] LastClr = ABITS'(NREGS - 2);

    typedef enum logic [1:0] {StClear, StIdle, StHi} state_e;

    state_e           state_q, state_d;
    logic [ABITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_data_q, hi_data_d;
    logic [ABITS-1:0] hi_addr_q, hi_addr_d;
    logic [WIDTH-1:0] mem_q [NStore];
    logic [WIDTH-1:0] mem_d [NStore];

    // Every state uses at most one write, so a single shared write port suffices.
    logic             wr_en;
    logic [ABITS-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Next-state, write-port selection and high-word capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_data_d = hi_data_q;
        hi_addr_d = hi_addr_q;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        unique case (state_q)
            StClear: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastClr) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (lwe) begin
                    // Long write has priority; any concurrent we3 is dropped.
                    wr_en     = 1'b1;
                    wr_addr   = lwa_lo;
                    wr_data   = lwd[WIDTH-1:0];
                    hi_data_d = lwd[2*WIDTH-1:WIDTH];
                    hi_addr_d = lwa_hi;
                    state_d   = StHi;
                end else if (we3) begin
                    wr_en   = 1'b1;
                    wr_addr = wa3;
                    wr_data = wd3;
                end
            end
            StHi: begin
                wr_en   = 1'b1;
                wr_addr = hi_addr_q;
                wr_data = hi_data_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    // Array update; writes to the PC alias or beyond are silently discarded.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr < PcAddr)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // State registers; reset restarts the clear and suppresses every array write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StClear;
            cnt_q     <= '0;
            hi_data_q <= '0;
            hi_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_data_q <= hi_data_d;
            hi_addr_q <= hi_addr_d;
            mem_q     <= mem_d;
        end
    end

    // Combinational reads with the PC alias; no write bypass.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 == PcAddr) begin
            rd1 = r15;
        end else if (ra1 < PcAddr) begin
            rd1 = mem_q[ra1];
        end
        if (ra2 == PcAddr) begin
            rd2 = r15;
        end else if (ra2 < PcAddr) begin
            rd2 = mem_q[ra2];
        end
    end

    // Busy is a pure decode of the registered state.
    always_comb begin
        busy = (state_q != StIdle);
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios followed by random traffic,
// all compared against a behavioural register-file model.
module tb_regfile_param;

    localparam int W = 32;
    localparam int N = 16;
    localparam int A = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           we3, lwe;
    logic [A-1:0]   wa3, lwa_lo, lwa_hi, ra1, ra2;
    logic [W-1:0]   wd3, r15, rd1, rd2;
    logic [2*W-1:0] lwd;
    logic           busy;

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(W), .NREGS(N), .ABITS(A)) dut (
        .clk    (clk),
        .reset  (reset),
        .we3    (we3),
        .wa3    (wa3),
        .wd3    (wd3),
        .lwe    (lwe),
        .lwa_lo (lwa_lo),
        .lwa_hi (lwa_hi),
        .lwd    (lwd),
        .ra1    (ra1),
        .ra2    (ra2),
        .r15    (r15),
        .rd1    (rd1),
        .rd2    (rd2),
        .busy   (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stored registers, clear progress and a pending high-word write.
    logic [W-1:0] ref_mem [N-1];
    bit           ref_clearing;
    int           ref_clr_idx;
    bit           ref_pend;
    int           ref_pend_addr;
    logic [W-1:0] ref_pend_data;

    function automatic void ref_write(int addr, logic [W-1:0] d);
        if (addr < N - 1) ref_mem[addr] = d;
    endfunction

    function automatic logic [W-1:0] ref_read(int addr, logic [W-1:0] pc);
        if (addr == N - 1) return pc;
        if (addr < N - 1) return ref_mem[addr];
        return '0;
    endfunction

    task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then check busy.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            ref_clearing = 1'b1;
            ref_clr_idx  = 0;
            ref_pend     = 1'b0;
        end else if (ref_clearing) begin
            ref_write(ref_clr_idx, '0);
            ref_clr_idx++;
            if (ref_clr_idx == N - 1) ref_clearing = 1'b0;
        end else if (ref_pend) begin
            ref_write(ref_pend_addr, ref_pend_data);
            ref_pend = 1'b0;
        end else if (lwe) begin
            ref_write(int'(lwa_lo), lwd[W-1:0]);
            ref_pend      = 1'b1;
            ref_pend_addr = int'(lwa_hi);
            ref_pend_data = lwd[2*W-1:W];
        end else if (we3) begin
            ref_write(int'(wa3), wd3);
        end
        #1;
        check("busy", W'(busy), W'(ref_clearing || ref_pend));
    endtask

    task automatic rd_const(string tag, int addr, logic [W-1:0] exp);
        ra1 = A'(addr);
        ra2 = A'(addr);
        #1;
        check({tag, "_rd1"}, rd1, exp);
        check({tag, "_rd2"}, rd2, exp);
    endtask

    task automatic sweep_model(string tag);
        for (int i = 0; i < N; i++) begin
            ra1 = A'(i);
            ra2 = A'(N - 1 - i);
            r15 = $urandom;
            #1;
            check({tag, "_rd1"}, rd1, ref_read(i, r15));
            check({tag, "_rd2"}, rd2, ref_read(N - 1 - i, r15));
        end
    endtask

    task automatic release_and_count(string tag);
        int cyc;
        reset = 1'b1;
        cyc   = 0;
        do begin
            tick();
            cyc++;
        end while (busy && cyc < 40);
        check(tag, W'(cyc), W'(N - 1));
    endtask

    initial begin
        reset = 1'b0; we3 = 1'b0; lwe = 1'b0;
        wa3 = '0; lwa_lo = '0; lwa_hi = '0; wd3 = '0; lwd = '0;
        ra1 = '0; ra2 = '0; r15 = '0;
        ref_clearing = 1'b1; ref_clr_idx = 0; ref_pend = 1'b0;
        ref_pend_addr = 0; ref_pend_data = '0;
        for (int i = 0; i < N - 1; i++) ref_mem[i] = '0;

        // Reset held: busy stays high, then clear runs for NREGS-1 edges.
        repeat (3) tick();
        release_and_count("clear_len");
        for (int i = 0; i < N - 1; i++) rd_const("clr_zero", i, '0);

        // Single write, PC alias, and no same-cycle bypass.
        we3 = 1'b1; wa3 = 4'd3; wd3 = 32'hDEADBEEF; ra1 = 4'd3;
        #1;
        check("no_bypass", rd1, 32'h0);
        tick();
        we3 = 1'b0;
        ra1 = 4'd3; ra2 = 4'd15; r15 = 32'h108;
        #1;
        check("we3_r3", rd1, 32'hDEADBEEF);
        check("pc_alias", rd2, 32'h108);

        // Long write; we3 during HI is ignored.
        lwe = 1'b1; lwa_lo = 4'd4; lwa_hi = 4'd5; lwd = 64'h11112222_33334444;
        tick();
        lwe = 1'b0;
        check("hi_busy", W'(busy), 32'd1);
        rd_const("lo_r4", 4, 32'h33334444);
        rd_const("r5_pre", 5, 32'h0);
        we3 = 1'b1; wa3 = 4'd6; wd3 = 32'd7;
        tick();
        we3 = 1'b0;
        rd_const("hi_r5", 5, 32'h11112222);
        rd_const("r6_ign", 6, 32'h0);

        // Simultaneous we3 and lwe: long write wins.
        we3 = 1'b1; wa3 = 4'd2; wd3 = 32'h55;
        lwe = 1'b1; lwa_lo = 4'd9; lwa_hi = 4'd10; lwd = 64'hCAFEF00D_0BADBEEF;
        tick();
        we3 = 1'b0; lwe = 1'b0;
        tick();
        rd_const("r2_drop", 2, 32'h0);
        rd_const("r9_lo", 9, 32'h0BADBEEF);
        rd_const("r10_hi", 10, 32'hCAFEF00D);

        // Same lo/hi address: high word lands last.
        lwe = 1'b1; lwa_lo = 4'd8; lwa_hi = 4'd8; lwd = 64'hAAAA0000_0000BBBB;
        tick();
        lwe = 1'b0;
        rd_const("r8_lo", 8, 32'h0000BBBB);
        tick();
        rd_const("r8_hi", 8, 32'hAAAA0000);

        // Write to the PC alias is discarded.
        we3 = 1'b1; wa3 = 4'd15; wd3 = 32'h12345678;
        tick();
        we3 = 1'b0;
        sweep_model("pc_wr");

        // Reset during HI: high word never written, clear restarts.
        lwe = 1'b1; lwa_lo = 4'd11; lwa_hi = 4'd12; lwd = 64'h77777777_66666666;
        tick();
        lwe = 1'b0; reset = 1'b0;
        tick();
        release_and_count("reclear_len");
        for (int i = 0; i < N - 1; i++) rd_const("reclr_zero", i, '0);

        // Random traffic, including occasional mid-operation resets.
        for (int c = 0; c < 400; c++) begin
            reset  = ($urandom_range(59) != 0);
            we3    = $urandom_range(1);
            lwe    = ($urandom_range(3) == 0);
            wa3    = A'($urandom_range(N - 1));
            lwa_lo = A'($urandom_range(N - 1));
            lwa_hi = A'($urandom_range(N - 1));
            wd3    = $urandom;
            lwd    = {$urandom, $urandom};
            tick();
            if (!ref_clearing) begin
                ra1 = A'($urandom_range(N - 1));
                ra2 = A'($urandom_range(N - 1));
                r15 = $urandom;
                #1;
                check("rnd_rd1", rd1, ref_read(int'(ra1), r15));
                check("rnd_rd2", rd2, ref_read(int'(ra2), r15));
            end
        end
        reset = 1'b1; we3 = 1'b0; lwe = 1'b0;
        repeat (N + 2) tick();
        sweep_model("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
